// File: rtl/fp_denorm.sv
// fp_denorm: IEEE-754 single-precision to signed fixed-point converter.
// The float exponent is turned into a shift count. The 24-bit mantissa is then
// denormalised by a 1-bit-per-cycle shifter into an OUT_W-bit magnitude.
// That magnitude is rounded, saturated and sign-applied.
// Optional build macro FP_DENORM_RNE_EN: round-to-nearest-even on right shifts.
// Without it, right shifts truncate the magnitude toward zero.
module fp_denorm #(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iFP,
  output logic             oValid,
  input  logic             iReady,
  output logic [OUT_W-1:0] oData,
  output logic             oOvf,
  output logic             oUnf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    SHIFT = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  // shift = exp - 127 + FRAC_W - 23, folded into one bias term
  localparam logic signed [9:0] S_BIAS = 10'(FRAC_W - 150);
  localparam logic signed [9:0] S_MAX  = 10'(OUT_W - 24);
  localparam logic signed [9:0] S_MIN  = -10'sd25;
  localparam logic [OUT_W:0]    POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]    NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  state_t             state_r;
  logic [31:0]        fp_r;
  logic [OUT_W-1:0]   mag_r;
  logic               guard_r;
  logic               sticky_r;
  logic               ovf_r;
  logic [6:0]         cnt_r;

  logic [7:0]         exp_s;
  logic signed [9:0]  shift_s;
  logic [6:0]         absShift_s;
  logic [OUT_W-1:0]   magInit_s;
  logic [OUT_W:0]     rnd_s;
  logic               sat_s;
  logic [OUT_W-1:0]   res_s;
  logic               unf_s;

  // Decode the latched float: exponent, signed shift count and its magnitude.
  // fp_r is stable after accept, so the shift direction is also taken from here.
  always_comb begin
    exp_s      = fp_r[30:23];
    shift_s    = $signed({2'b00, exp_s}) + S_BIAS;
    absShift_s = 7'd0;
    if (shift_s[9]) begin
      absShift_s = 7'(-shift_s);
    end else begin
      absShift_s = 7'(shift_s);
    end
    magInit_s  = {{(OUT_W-24){1'b0}}, 1'b1, fp_r[22:0]};
  end

  // Round the magnitude, detect saturation and form the signed result and flags.
  always_comb begin
`ifdef FP_DENORM_RNE_EN
    rnd_s = {1'b0, mag_r} + {{OUT_W{1'b0}}, (guard_r & (sticky_r | mag_r[0]))};
`else
    rnd_s = {1'b0, mag_r};
`endif
    sat_s = 1'b0;
    if (fp_r[31]) begin
      sat_s = ovf_r || (rnd_s > NEG_LIM);
    end else begin
      sat_s = ovf_r || (rnd_s > POS_LIM);
    end
    res_s = {OUT_W{1'b0}};
    if (sat_s) begin
      res_s = fp_r[31] ? SAT_NEG : SAT_POS;
    end else if (fp_r[31]) begin
      res_s = {OUT_W{1'b0}} - rnd_s[OUT_W-1:0];
    end else begin
      res_s = rnd_s[OUT_W-1:0];
    end
    unf_s = (fp_r[30:0] != 31'd0) && !sat_s && (res_s == {OUT_W{1'b0}});
  end

  // Control FSM with datapath registers and registered handshake/result outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r  <= IDLE;
      fp_r     <= 32'd0;
      mag_r    <= {OUT_W{1'b0}};
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= 7'd0;
      oReady   <= 1'b1;
      oValid   <= 1'b0;
      oData    <= {OUT_W{1'b0}};
      oOvf     <= 1'b0;
      oUnf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (iValid && oReady) begin
            fp_r     <= iFP;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            ovf_r    <= 1'b0;
            oReady   <= 1'b0;
            state_r  <= CALC;
          end else begin
            state_r  <= IDLE;
          end
        end
        CALC: begin
          if (exp_s == 8'd255) begin
            // Inf and NaN saturate; magnitude is irrelevant
            mag_r   <= {OUT_W{1'b0}};
            ovf_r   <= 1'b1;
            state_r <= ROUND;
          end else if (exp_s == 8'd0) begin
            // zero and denormals flush to zero
            mag_r   <= {OUT_W{1'b0}};
            state_r <= ROUND;
          end else if (shift_s > S_MAX) begin
            mag_r   <= magInit_s;
            ovf_r   <= 1'b1;
            state_r <= ROUND;
          end else if (shift_s < S_MIN) begin
            mag_r   <= {OUT_W{1'b0}};
            state_r <= ROUND;
          end else if (shift_s == 10'sd0) begin
            mag_r   <= magInit_s;
            state_r <= ROUND;
          end else begin
            mag_r   <= magInit_s;
            cnt_r   <= absShift_s;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (!shift_s[9]) begin
            mag_r    <= {mag_r[OUT_W-2:0], 1'b0};
          end else begin
            mag_r    <= {1'b0, mag_r[OUT_W-1:1]};
            guard_r  <= mag_r[0];
            sticky_r <= sticky_r | guard_r;
          end
          cnt_r <= cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            state_r <= ROUND;
          end else begin
            state_r <= SHIFT;
          end
        end
        ROUND: begin
          oData   <= res_s;
          oOvf    <= sat_s;
          oUnf    <= unf_s;
          oValid  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (iReady) begin
            oValid  <= 1'b0;
            oReady  <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          oValid  <= 1'b0;
          oReady  <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_denorm.sv
// Testbench for fp_denorm (OUT_W=32, FRAC_W=8): vector table through a
// scoreboard queue, plus hand-written backpressure and mid-shift reset sequences.
module tb_fp_denorm;

  localparam int OUT_W  = 32;
  localparam int FRAC_W = 8;
`ifdef FP_DENORM_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic             clk;
  logic             rstN;
  logic             inValid;
  logic             outReady;
  logic [31:0]      fpWord;
  logic             outValid;
  logic             dsReady;
  logic [OUT_W-1:0] outData;
  logic             outOvf;
  logic             outUnf;

  typedef struct {
    logic [31:0] fp;
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    int          lat;
    string       name;
  } exp_t;

  vec_t vecs[19];
  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  fp_denorm #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
    .iClk   (clk),
    .iRst_n (rstN),
    .iValid (inValid),
    .oReady (outReady),
    .iFP    (fpWord),
    .oValid (outValid),
    .iReady (dsReady),
    .oData  (outData),
    .oOvf   (outOvf),
    .oUnf   (outUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; returns #1 after the accept edge with iValid dropped.
  task automatic sendWord(input logic [31:0] word, input string name);
    int waitCnt = 0;
    while (outReady !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    check({name, "_ready"}, 64'(outReady), 64'd1);
    inValid = 1'b1;
    fpWord  = word;
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  // Waits (bounded) for oValid; returns the number of edges counted from the accept edge.
  task automatic waitValid(output int edges);
    edges = 1;
    @(negedge clk);
    while (outValid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic compareHead(input int edges);
    exp_t e;
    if (sbQ.size() == 0) begin
      check("scoreboard_underflow", 64'd0, 64'd1);
    end else begin
      e = sbQ.pop_front();
      if (outValid !== 1'b1) begin
        check({e.name, "_timeout"}, 64'(outValid), 64'd1);
      end else begin
        check({e.name, "_data"}, 64'(outData), 64'(e.data));
        check({e.name, "_ovf"},  64'(outOvf),  64'(e.ovf));
        check({e.name, "_unf"},  64'(outUnf),  64'(e.unf));
        check({e.name, "_lat"},  64'(edges),   64'(e.lat));
      end
    end
  endtask

  task automatic runVec(input vec_t v);
    int edges;
    exp_t e;
    e = '{v.data, v.ovf, v.unf, v.lat, v.name};
    sbQ.push_back(e);
    sendWord(v.fp, v.name);
    waitValid(edges);
    compareHead(edges);
    @(posedge clk);
    @(negedge clk);
    check({v.name, "_valid_clear"}, 64'(outValid), 64'd0);
  endtask

  initial begin
    int edges;
    logic [31:0] held;

    vecs[0]  = '{32'h3F800000, 32'h00000100, 1'b0, 1'b0, 18, "one"};
    vecs[1]  = '{32'hC0200000, 32'hFFFFFD80, 1'b0, 1'b0, 17, "minus2p5"};
    vecs[2]  = '{32'hCB000000, 32'h80000000, 1'b0, 1'b0, 11, "negLimit"};
    vecs[3]  = '{32'h4B000000, 32'h7FFFFFFF, 1'b1, 1'b0, 11, "posOvf"};
    vecs[4]  = '{32'h501502F9, 32'h7FFFFFFF, 1'b1, 1'b0, 3,  "clampHi"};
    vecs[5]  = '{32'h3B400000, RNE ? 32'h1 : 32'h0, 1'b0, !RNE, 27, "lsb075"};
    vecs[6]  = '{32'h3B000000, 32'h00000000, 1'b0, 1'b1, 27, "lsb05"};
    vecs[7]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 3,  "nan"};
    vecs[8]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 3,  "negInf"};
    vecs[9]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b1, 3,  "denorm"};
    vecs[10] = '{32'h80000000, 32'h00000000, 1'b0, 1'b0, 3,  "negZero"};
    vecs[11] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 3,  "posZero"};
    vecs[12] = '{32'h47000000, 32'h00800000, 1'b0, 1'b0, 3,  "shiftZero"};
    vecs[13] = '{32'h3A000000, 32'h00000000, 1'b0, 1'b1, 3,  "clampLo"};
    vecs[14] = '{32'h3A800000, 32'h00000000, 1'b0, 1'b1, 28, "worstCase"};
    vecs[15] = '{32'h3BC00000, RNE ? 32'h2 : 32'h1, 1'b0, 1'b0, 26, "lsb15"};
    vecs[16] = '{32'h3C200000, 32'h00000002, 1'b0, 1'b0, 25, "lsb25"};
    vecs[17] = '{32'hBB400000, RNE ? 32'hFFFFFFFF : 32'h0, 1'b0, !RNE, 27, "negLsb075"};
    vecs[18] = '{32'h4AFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 10, "maxPos"};

    rstN    = 1'b0;
    inValid = 1'b0;
    dsReady = 1'b1;
    fpWord  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(outReady), 64'd1);
    check("rst_valid", 64'(outValid), 64'd0);
    check("rst_data",  64'(outData),  64'd0);
    check("rst_ovf",   64'(outOvf),   64'd0);
    check("rst_unf",   64'(outUnf),   64'd0);
    rstN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      runVec(vecs[i]);
    end

    // Backpressure: result held for 5 cycles while a new word is offered.
    dsReady = 1'b0;
    sbQ.push_back('{32'h00000100, 1'b0, 1'b0, 18, "hold"});
    sendWord(32'h3F800000, "hold");
    waitValid(edges);
    compareHead(edges);
    held    = outData;
    inValid = 1'b1;
    fpWord  = 32'h40000000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_data",  64'(outData),  64'(32'h00000100));
      check("hold_valid", 64'(outValid), 64'd1);
      check("hold_ready", 64'(outReady), 64'd0);
    end
    dsReady = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_valid", 64'(outValid), 64'd0);
    check("release_ready", 64'(outReady), 64'd1);
    repeat (3) @(negedge clk);
    check("no_phantom_valid", 64'(outValid), 64'd0);

    // Reset pulse in the middle of a shift sequence aborts with no output.
    sendWord(32'h3F800000, "abort");
    repeat (5) @(negedge clk);
    check("abort_busy", 64'(outReady), 64'd0);
    rstN = 1'b0;
    #1;
    check("abort_ready", 64'(outReady), 64'd1);
    check("abort_valid", 64'(outValid), 64'd0);
    check("abort_data",  64'(outData),  64'd0);
    check("abort_ovf",   64'(outOvf),   64'd0);
    check("abort_unf",   64'(outUnf),   64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    runVec(vecs[1]);
    check("scoreboard_empty", 64'(sbQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
